piso_stream: RTL and testbench

Parameterised parallel-in/serial-out serializer with a valid/ready load handshake and a one-word holding buffer. Words stream back-to-back with no idle bit between them. Bit order is selected per word, and a shift-enable input paces the bit rate. It sits between a word-wide producer and a bit-serial link (UART/SPI-style transmit path), replacing the plain load/shift PISO.

---
 rtl/piso_stream.sv | 116 +++++++++++
 tb/tb_piso_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// Parallel-in/serial-out streamer with valid/ready load, one-word holding buffer
// and per-word bit order; shift_en paces the bit rate.
module piso_stream #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] parallel_in,
   input  logic         in_msb_first,
   input  logic         shift_en,
   output logic         serial_out,
   output logic         serial_valid,
   output logic         serial_last,
   busy
);

   // state | meaning
   // IDLE  | nothing to send, holding buffer empty
   // SHIFT | shifter presents a data bit on serial_out
   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t         state_q, state_d;
   logic [N-1:0]   sh_q, sh_d;
   logic           dir_q, dir_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   hold_q, hold_d;
   logic           hold_dir_q, hold_dir_d;
   logic           hold_full_q, hold_full_d;
   logic           xfer;

   assign in_ready     = !hold_full_q;
   assign xfer         = in_valid && !hold_full_q;
   assign serial_valid = (state_q == SHIFT);
   assign serial_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
   assign serial_out   = (state_q == SHIFT) && (dir_q ? sh_q[N-1] : sh_q[0]);
   assign busy         = (state_q == SHIFT) || hold_full_q;

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_dir_d  = hold_dir_q;
      hold_full_d = hold_full_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               sh_d    = parallel_in;
               dir_d   = in_msb_first;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en && (cnt_q == CNT_LAST)) begin
               // Held word always goes first so acceptance order is preserved.
               if (hold_full_q) begin
                  sh_d        = hold_q;
                  dir_d       = hold_dir_q;
                  cnt_d       = '0;
                  hold_full_d = 1'b0;
                  if (xfer) begin
                     hold_d      = parallel_in;
                     hold_dir_d  = in_msb_first;
                     hold_full_d = 1'b1;
                  end
               end else if (xfer) begin
                  sh_d  = parallel_in;
                  dir_d = in_msb_first;
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (shift_en) begin
                  sh_d  = dir_q ? (sh_q << 1) : (sh_q >> 1);
                  cnt_d = cnt_q + CW'(1);
               end
               if (xfer) begin
                  hold_d      = parallel_in;
                  hold_dir_d  = in_msb_first;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_dir_q  <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_dir_q  <= hold_dir_d;
         hold_full_q <= hold_full_d;
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: bit-level scoreboard queue filled on acceptance and
// drained on shift_en, checked every cycle on the falling edge.
module tb_piso_stream;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, in_msb_first, shift_en;
   logic         serial_out, serial_valid, serial_last, busy;
   logic [N-1:0] parallel_in, in_seq;

   piso_stream #(.N(N)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .parallel_in(parallel_in), .in_msb_first(in_msb_first), .shift_en(shift_en),
      .serial_out(serial_out), .serial_valid(serial_valid),
      .serial_last(serial_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {bit b; bit last;} sb_t;
   typedef struct {logic [7:0] data; logic msb; logic [7:0] seq;} vec_t;

   sb_t  q[$];
   vec_t tbl[6];
   int   total = 0;
   int   bad   = 0;
   bit   chk_on = 0;
   bit   accepted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // seq bit i is the i-th bit put on the line
   function automatic logic [N-1:0] order(input logic [N-1:0] d, input logic msb);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = msb ? d[N-1-i] : d[i];
      return r;
   endfunction

   // Check at the falling edge, then advance the model over one rising edge.
   task automatic cyc();
      bit acc;
      if (chk_on) begin
         chk("serial_valid", serial_valid, q.size() != 0);
         chk("busy", busy, q.size() != 0);
         chk("in_ready", in_ready, q.size() <= N);
         if (q.size() != 0) begin
            chk("serial_out", serial_out, q[0].b);
            chk("serial_last", serial_last, q[0].last);
         end else begin
            chk("serial_out_idle", serial_out, 1'b0);
            chk("serial_last_idle", serial_last, 1'b0);
         end
      end
      acc = !reset && in_valid && (q.size() <= N);
      @(posedge clk);
      if (reset) q.delete();
      else begin
         if (shift_en && q.size() != 0) q.delete(0);
         if (acc)
            for (int i = 0; i < N; i++) q.push_back('{b: in_seq[i], last: (i == N - 1)});
      end
      accepted = acc;
      @(negedge clk);
   endtask

   task automatic drive(input logic [N-1:0] d, input logic msb, input logic [N-1:0] seq);
      in_valid     = 1'b1;
      parallel_in  = d;
      in_msb_first = msb;
      in_seq       = seq;
   endtask

   task automatic idle_inputs();
      in_valid     = 1'b0;
      parallel_in  = N'($urandom);
      in_msb_first = 1'($urandom);
   endtask

   // Run until the model drains; returns the number of valid cycles seen.
   task automatic drain(input int max, output int vcnt);
      int n = 0;
      vcnt = 0;
      while (q.size() != 0 && n < max) begin
         vcnt++;
         cyc();
         idle_inputs();
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
   endtask

   initial begin
      int vcnt, k, guard;
      logic [N-1:0] w[3];
      tbl[0] = '{8'h1E, 1'b0, 8'h1E};
      tbl[1] = '{8'h1E, 1'b1, 8'h78};
      tbl[2] = '{8'h01, 1'b0, 8'h01};
      tbl[3] = '{8'h80, 1'b1, 8'h01};
      tbl[4] = '{8'hC8, 1'b1, 8'h13};
      tbl[5] = '{8'h6B, 1'b0, 8'h6B};

      // reset held two cycles with in_valid and shift_en active
      reset = 1'b1; shift_en = 1'b1;
      drive(8'hFF, 1'b1, 8'hFF);
      cyc();
      chk_on = 1;
      cyc();
      reset = 1'b0;
      idle_inputs();
      cyc();

      foreach (tbl[i]) begin
         shift_en = 1'b1;
         drive(tbl[i].data, tbl[i].msb, tbl[i].seq);
         cyc();
         chk("tbl_accept", accepted, 1'b1);
         idle_inputs();
         drain(20, vcnt);
         chk("tbl_len", vcnt, N);
         cyc();
      end

      // continuous in_valid: three words back to back
      w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF;
      k = 0; guard = 0; vcnt = 0; shift_en = 1'b1;
      while (k < 3 && guard < 100) begin
         if (q.size() != 0) vcnt++;
         drive(w[k], 1'b0, w[k]);
         cyc();
         if (accepted) k++;
         guard++;
      end
      chk("b2b_accepted", k, 3);
      idle_inputs();
      drain(40, guard);
      chk("b2b_valid_run", vcnt + guard, 3 * N);

      // shift_en every other cycle
      drive(8'hA5, 1'b0, 8'hA5);
      cyc();
      idle_inputs();
      vcnt = 0; guard = 0; shift_en = 1'b0;
      while (q.size() != 0 && guard < 40) begin
         vcnt++;
         cyc();
         idle_inputs();
         shift_en = ~shift_en;
         guard++;
      end
      chk("slow_span", vcnt, 2 * N);
      shift_en = 1'b1;
      cyc();

      // reset with a word in flight and one held
      drive(8'hF0, 1'b0, 8'hF0);
      cyc();
      drive(8'h0F, 1'b0, 8'h0F);
      cyc();
      chk("hold_accept", accepted, 1'b1);
      idle_inputs();
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("post_reset_quiet", serial_valid, 1'b0);
         cyc();
      end
      drive(8'h33, 1'b1, order(8'h33, 1'b1));
      cyc();
      idle_inputs();
      drain(20, vcnt);
      chk("post_reset_len", vcnt, N);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
